detector_jogada: RTL
====================

// Module: detector_jogada
// PURPOSE
//  Front-end input stage that sits directly upstream of the game datapath/control unit.
//  It synchronizes and debounces the 4 player keys (chaves).
//  Each accepted press produces exactly one registered jogada plus a 1-cycle jogada_feita pulse.
//  Multi-key presses are flagged with jogada_invalida instead.
//  The block then waits for a debounced release before arming for the next play.
// PARAMETERS
//  DEBOUNCE_CYCLES  3   consecutive stable cycles required for press and for release (>=1)
//  CNT_W            4   debounce counter width; 2**CNT_W must be > DEBOUNCE_CYCLES
// PORTS
//  clock            in   1  system clock, rising edge
//  reset            in   1  asynchronous, active-low; 0 forces reset state immediately
//  habilita         in   1  from control unit; 1 = plays may be accepted
//  limpa            in   1  synchronous clear of jogada register (priority below reset)
//  chaves           in   4  raw keys, asynchronous to clock
//  jogada           out  4  last accepted one-hot play, held until next accept/limpa
//  jogada_feita     out  1  1-cycle pulse: jogada just updated with a valid play
//  jogada_invalida  out  1  1-cycle pulse: debounced press was not one-hot
//  db_tem_jogada    out  1  |chaves after synchronizer (debug)
//  db_estado        out  3  current FSM state code (debug)
// BEHAVIOUR
//  Reset (reset=0): state=ESPERA, sync regs=0, amostra=0, contador=0, jogada=4'b0000;
//   jogada_feita=0, jogada_invalida=0, db_tem_jogada=0, db_estado=3'd0.
//  Synchronizer: 2-FF chain sync1<=chaves, sync2<=sync1. All FSM decisions use sync2 only.
//  FSM (db_estado code):
//   ESPERA(0): if habilita && sync2!=0 -> FILTRO, amostra<=sync2, contador<=0.
//   FILTRO(1): if !habilita -> ESPERA.
//    Else if sync2==0 -> ESPERA (glitch rejected, no pulse).
//    Else if sync2!=amostra -> stay, amostra<=sync2, contador<=0.
//    Else if contador==DEBOUNCE_CYCLES-1 -> REGISTRA.
//    Else contador<=contador+1.
//   REGISTRA(2), exactly 1 cycle, then -> SOLTA with contador<=0:
//    If amostra is one-hot: jogada<=amostra, jogada_feita=1.
//    Otherwise: jogada unchanged, jogada_invalida=1.
//   SOLTA(3): if sync2!=0 -> contador<=0.
//    Else if contador==DEBOUNCE_CYCLES-1 -> ESPERA.
//    Else contador<=contador+1.
//    habilita is ignored here, so a held key is never re-accepted.
//  Outputs jogada_feita/jogada_invalida are Moore outputs of REGISTRA. They are never both 1.
//  Latency: keys stable from edge k -> pulse high in the cycle after edge k+2+DEBOUNCE_CYCLES.
//  One pulse per press regardless of hold length. A new press during SOLTA is ignored until full release.
//  limpa=1: jogada<=0 on that edge. If limpa coincides with REGISTRA, limpa wins on jogada,
//   but jogada_feita still pulses. FSM is unaffected.
//  habilita falling mid-FILTRO aborts the press (no pulse). Falling in REGISTRA/SOLTA has no effect.
//  reset asserted mid-operation: immediate return to reset values; any pending pulse is lost.
//  Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 in every state.
//  Unused state codes (4..7) -> ESPERA on next edge.
// TESTING (DEBOUNCE_CYCLES=3, clock 20 ns)
//  1) reset=0 for 1 cycle with chaves=4'b0100 -> all outputs 0, db_estado=0; press not accepted until
//     reset=1 and the normal latency elapses.
//  2) habilita=1, chaves=4'b0001 held 5 cycles then 0 -> jogada=4'b0001.
//     jogada_feita is high exactly 1 cycle, at edge k+5. db_estado returns to 0 after release + 3 cycles.
//  3) chaves=4'b0010 held 40 cycles -> exactly one jogada_feita pulse; jogada=4'b0010 stays until next play.
//  4) chaves=4'b1000 for 2 cycles then 0 -> no pulse, jogada unchanged, FSM back to ESPERA.
//  5) chaves=4'b0110 held 6 cycles -> jogada_invalida one 1-cycle pulse, jogada unchanged, jogada_feita=0.
//  6) habilita=0, chaves=4'b0100 -> no pulse.
//     Then drop habilita in FILTRO -> abort.
//     Then assert limpa -> jogada=0 next edge.

Source files
------------

// File: rtl/detector_jogada.sv
// Key input front-end: 2-FF synchronizer, debounce FSM and one-hot play register.
// Emits one jogada_feita or jogada_invalida pulse per press, then waits for a debounced release.
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int CNT_W           = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic       limpa,
   input  logic [3:0] chaves,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       jogada_invalida,
   output logic       db_tem_jogada,
   output logic [2:0] db_estado
);

   typedef enum logic [2:0] {
      ESPERA   = 3'd0,
      FILTRO   = 3'd1,
      REGISTRA = 3'd2,
      SOLTA    = 3'd3
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   estado_t          r_estado;
   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       r_amostra;
   logic [3:0]       r_jogada;
   logic [CNT_W-1:0] r_contador;
   logic             r_feita;
   logic             r_invalida;
   logic             w_um_quente;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign w_um_quente = (r_amostra != 4'd0) && ((r_amostra & (r_amostra - 4'd1)) == 4'd0);

   // NOTE: every register below uses <= so all state updates see pre-edge values;
   // the pulses are registered on entry to REGISTRA so they are glitch-free Moore outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado   <= ESPERA;
         r_sync1    <= 4'd0;
         r_sync2    <= 4'd0;
         r_amostra  <= 4'd0;
         r_jogada   <= 4'd0;
         r_contador <= '0;
         r_feita    <= 1'b0;
         r_invalida <= 1'b0;
      end else begin
         r_sync1    <= chaves;
         r_sync2    <= r_sync1;
         r_feita    <= 1'b0;
         r_invalida <= 1'b0;

         if (limpa)
            r_jogada <= 4'd0;
         else if (r_estado == REGISTRA && w_um_quente)
            r_jogada <= r_amostra;

         case (r_estado)
            ESPERA: begin
               if (habilita && r_sync2 != 4'd0) begin
                  r_estado   <= FILTRO;
                  r_amostra  <= r_sync2;
                  r_contador <= '0;
               end
            end
            FILTRO: begin
               if (!habilita || r_sync2 == 4'd0) begin
                  r_estado <= ESPERA;
               end else if (r_sync2 != r_amostra) begin
                  r_amostra  <= r_sync2;
                  r_contador <= '0;
               end else if (r_contador == CNT_MAX) begin
                  r_estado   <= REGISTRA;
                  r_feita    <= w_um_quente;
                  r_invalida <= !w_um_quente;
               end else begin
                  r_contador <= r_contador + CNT_W'(1);
               end
            end
            REGISTRA: begin
               r_estado   <= SOLTA;
               r_contador <= '0;
            end
            SOLTA: begin
               // habilita deliberately ignored: a held key must never be re-accepted.
               if (r_sync2 != 4'd0)
                  r_contador <= '0;
               else if (r_contador == CNT_MAX)
                  r_estado <= ESPERA;
               else
                  r_contador <= r_contador + CNT_W'(1);
            end
            default: r_estado <= ESPERA;
         endcase
      end
   end

   assign jogada          = r_jogada;
   assign jogada_feita    = r_feita;
   assign jogada_invalida = r_invalida;
   assign db_tem_jogada   = |r_sync2;
   assign db_estado       = r_estado;

endmodule
